// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register window offsets,
// CAUSE register field positions, source indices and FSM state encoding.
package irq_ctrl_pkg;

    localparam logic [1:0] IRQ_MASK  = 2'b00;
    localparam logic [1:0] IRQ_PEND  = 2'b01;
    localparam logic [1:0] IRQ_CAUSE = 2'b10;
    localparam logic [1:0] IRQ_CTRL  = 2'b11;

    // CAUSE = {24'b0, in_srv, id_srv[2:0], 1'b0, int_id[2:0]}
    localparam int CAUSE_INT_ID_LSB = 0;
    localparam int CAUSE_ID_SRV_LSB = 4;
    localparam int CAUSE_IN_SRV_BIT = 7;

    localparam int SRC_TIMER = 0;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } irq_state_e;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-first priority encoder: index 0 wins, id is 0 when nothing is set.
module irq_prio_enc #(
    parameter int NSRC = 6
) (
    input  logic [NSRC-1:0] req_i,
    output logic [2:0]      id_o,
    output logic            valid_o
);

    // Scanning from the top down lets the lowest set index overwrite last.
    always_comb begin
        id_o    = 3'd0;
        valid_o = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o    = 3'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller with mask/pending/cause/ctrl register window and a
// request/ack/eret handshake. Define IRQ_CTRL_EDGE_EN for sticky edge-triggered pending bits.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      addr_i,
    input  logic            we_i,
    input  logic [31:0]     din_i,
    output logic [31:0]     dout_o,
    input  logic [NSRC-1:0] hw_irq_i,
    input  logic            int_ack_i,
    input  logic            eret_i,
    output logic            int_req_o,
    output logic [2:0]      int_id_o
);

    logic [NSRC-1:0] hw_q;
    logic [NSRC-1:0] mask_q, mask_d;
    logic            ie_q, ie_d;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] eff;
    logic [2:0]      eff_id;
    logic            eff_valid;
    irq_state_e      state_q, state_d;
    logic [2:0]      id_srv_q, id_srv_d;
    logic            in_srv;
    logic            take;
    logic            din_unused;

    assign din_unused = ^din_i[31:NSRC];

    assign eff = pend & mask_q;

    irq_prio_enc #(
        .NSRC (NSRC)
    ) u_prio_enc (
        .req_i   (eff),
        .id_o    (eff_id),
        .valid_o (eff_valid)
    );

    assign in_srv    = (state_q == ST_SERVICE);
    assign int_req_o = ie_q & eff_valid & ~in_srv;
    assign int_id_o  = eff_id;
    assign take      = int_ack_i & int_req_o;

    always_comb begin
        mask_d = mask_q;
        ie_d   = ie_q;
        if (we_i && addr_i == IRQ_MASK) mask_d = din_i[NSRC-1:0];
        if (we_i && addr_i == IRQ_CTRL) ie_d = din_i[0];
    end

    // An ack is only honoured from IDLE; eret in SERVICE always wins over a same-cycle ack.
    always_comb begin
        state_d  = state_q;
        id_srv_d = id_srv_q;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d  = ST_SERVICE;
                    id_srv_d = eff_id;
                end
            end
            ST_SERVICE: begin
                if (eret_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hw_q     <= '0;
            mask_q   <= '0;
            ie_q     <= 1'b0;
            state_q  <= ST_IDLE;
            id_srv_q <= 3'd0;
        end else begin
            hw_q     <= hw_irq_i;
            mask_q   <= mask_d;
            ie_q     <= ie_d;
            state_q  <= state_d;
            id_srv_q <= id_srv_d;
        end
    end

`ifdef IRQ_CTRL_EDGE_EN
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] ack_clr;

    // New rising edges are OR-ed in last so a set always beats a same-cycle clear.
    always_comb begin
        w1c     = '0;
        ack_clr = '0;
        if (we_i && addr_i == IRQ_PEND) w1c = din_i[NSRC-1:0];
        for (int i = 0; i < NSRC; i++) begin
            ack_clr[i] = take && (eff_id == 3'(i));
        end
        pend_d = (pend_q & ~w1c & ~ack_clr) | (hw_irq_i & ~hw_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;
`else
    assign pend = hw_q;
`endif

    always_comb begin
        dout_o = '0;
        unique case (addr_i)
            IRQ_MASK:  dout_o[NSRC-1:0] = mask_q;
            IRQ_PEND:  dout_o[NSRC-1:0] = pend;
            IRQ_CAUSE: begin
                dout_o[CAUSE_IN_SRV_BIT]        = in_srv;
                dout_o[CAUSE_ID_SRV_LSB +: 3]   = id_srv_q;
                dout_o[CAUSE_INT_ID_LSB +: 3]   = eff_id;
            end
            IRQ_CTRL:  dout_o[0] = ie_q;
            default:   dout_o = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomized scoreboard bench for irq_ctrl: a behavioural model predicts every
// cycle's int_req/int_id/dout, and a negedge monitor compares against the DUT.
module tb_irq_ctrl;

    localparam int NSRC = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      addr = 2'b00;
    logic            we = 1'b0;
    logic [31:0]     din = '0;
    logic [31:0]     dout;
    logic [NSRC-1:0] hwIrq = '0;
    logic            intAck = 1'b0;
    logic            eret = 1'b0;
    logic            intReq;
    logic [2:0]      intId;

    irq_ctrl #(
        .NSRC (NSRC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr_i    (addr),
        .we_i      (we),
        .din_i     (din),
        .dout_o    (dout),
        .hw_irq_i  (hwIrq),
        .int_ack_i (intAck),
        .eret_i    (eret),
        .int_req_o (intReq),
        .int_id_o  (intId)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          req;
        bit [2:0]    id;
        logic [31:0] rd;
        bit [1:0]    a;
    } expect_t;

    expect_t expQ[$];
    int checks = 0;
    int passes = 0;

    // Behavioural model state
    bit [NSRC-1:0] mMask, mPend, mHwQ;
    bit            mIe, mInSrv;
    int            mIdSrv;
    bit [NSRC-1:0] hwCur = '0;

    function automatic int lowestSet(input bit [NSRC-1:0] v);
        for (int i = 0; i < NSRC; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit modelReq();
        return mIe && (lowestSet(mPend & mMask) >= 0) && !mInSrv;
    endfunction

    function automatic int modelId();
        int k;
        k = lowestSet(mPend & mMask);
        return (k < 0) ? 0 : k;
    endfunction

    function automatic logic [31:0] modelRead(input bit [1:0] a);
        logic [31:0] v;
        v = 0;
        case (a)
            2'd0: v = 32'(mMask);
            2'd1: v = 32'(mPend);
            2'd2: v = 32'(mInSrv) * 128 + 32'(mIdSrv) * 16 + 32'(modelId());
            default: v = 32'(mIe);
        endcase
        return v;
    endfunction

    task automatic modelStep(input bit r, input bit w, input bit [1:0] a,
                             input logic [31:0] d, input bit [NSRC-1:0] h,
                             input bit ack, input bit er);
        bit            reqPre;
        int            idPre;
        bit [NSRC-1:0] hwOld;
        if (r) begin
            mMask = 0; mPend = 0; mHwQ = 0; mIe = 0; mInSrv = 0; mIdSrv = 0;
            return;
        end
        reqPre = modelReq();
        idPre  = modelId();
        hwOld  = mHwQ;
        mHwQ   = h;
        if (w && a == 2'd0) mMask = d[NSRC-1:0];
        if (w && a == 2'd3) mIe = d[0];
`ifdef IRQ_CTRL_EDGE_EN
        for (int i = 0; i < NSRC; i++) begin
            if (h[i] && !hwOld[i])
                mPend[i] = 1'b1;
            else if ((w && a == 2'd1 && d[i]) || (ack && reqPre && idPre == i))
                mPend[i] = 1'b0;
        end
`else
        mPend = mHwQ;
`endif
        if (mInSrv) begin
            if (er) mInSrv = 0;
        end else if (ack && reqPre) begin
            mInSrv = 1;
            mIdSrv = idPre;
        end
    endtask

    // Drives one cycle of inputs, queues the expected outputs, then advances the model.
    task automatic applyStimulus(input bit r, input bit w, input bit [1:0] a,
                                 input logic [31:0] d, input bit [NSRC-1:0] h,
                                 input bit ack, input bit er);
        expect_t e;
        rst = r; we = w; addr = a; din = d; hwIrq = h; intAck = ack; eret = er;
        e.req = modelReq();
        e.id  = 3'(modelId());
        e.rd  = modelRead(a);
        e.a   = a;
        expQ.push_back(e);
        @(posedge clk);
        modelStep(r, w, a, d, h, ack, er);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 2'($urandom), 0, hwCur, 0, 0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("int_req", 32'(intReq), 32'(e.req));
                checkOutput("int_id", 32'(intId), 32'(e.id));
                checkOutput($sformatf("dout[addr=%0d]", e.a), dout, e.rd);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // Timer edge with only source 0 unmasked
        applyStimulus(0, 1, 2'd3, 32'h1, 0, 0, 0);
        applyStimulus(0, 1, 2'd0, 32'h01, 0, 0, 0);
        hwCur = 6'h01; idle(1);
        hwCur = 6'h00; idle(2);
        applyStimulus(0, 0, 2'd2, 0, hwCur, 1, 0);
        applyStimulus(0, 0, 2'd2, 0, hwCur, 0, 1);
        applyStimulus(0, 1, 2'd1, 32'h3F, hwCur, 0, 0);
        // Two sources pending: id 2 first, then 5 after eret
        applyStimulus(0, 1, 2'd0, 32'h3F, hwCur, 0, 0);
        hwCur = 6'b100100; idle(2);
        applyStimulus(0, 0, 2'd2, 0, hwCur, 1, 0);
        idle(1);
        applyStimulus(0, 0, 2'd1, 0, hwCur, 0, 1);
        idle(1);
        applyStimulus(0, 0, 2'd2, 0, hwCur, 1, 0);
        applyStimulus(0, 0, 2'd2, 0, hwCur, 1, 1);
        idle(1);
        // W1C colliding with a fresh edge on the same bit
        hwCur = 6'b000000; idle(1);
        applyStimulus(0, 1, 2'd1, 32'h04, 6'b000100, 0, 0);
        hwCur = 6'b000100; idle(1);
        // Fully pending, gated by mask then by IE
        applyStimulus(0, 0, 2'd0, 0, hwCur, 0, 1);
        hwCur = 6'h00; idle(1);
        hwCur = 6'h3F; idle(1);
        applyStimulus(0, 1, 2'd0, 32'h0, hwCur, 0, 0);
        idle(2);
        applyStimulus(0, 1, 2'd0, 32'h08, hwCur, 0, 0);
        idle(1);
        applyStimulus(0, 1, 2'd3, 32'h0, hwCur, 0, 0);
        idle(1);
        applyStimulus(0, 1, 2'd3, 32'h1, hwCur, 0, 0);
        // Reset while in service with pending bits set
        applyStimulus(0, 0, 2'd2, 0, hwCur, 1, 0);
        applyStimulus(1, 0, 2'd2, 0, hwCur, 0, 0);
        for (int a = 0; a < 4; a++) applyStimulus(0, 0, 2'(a), 0, hwCur, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bit r, w, ack, er;
            bit [1:0] a;
            logic [31:0] d;
            if (($urandom % 100) < 20) hwCur = NSRC'($urandom);
            r   = (($urandom % 200) == 0);
            w   = (($urandom % 100) < 20);
            a   = 2'($urandom);
            d   = $urandom;
            if (w && a == 2'd3 && ($urandom % 4) != 0) d[0] = 1'b1;
            ack = (($urandom % 100) < 30);
            er  = (($urandom % 100) < 20);
            applyStimulus(r, w, a, d, hwCur, ack, er);
        end
        idle(1);
        @(negedge clk);
        #1;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
